// File: rtl/amo_responder_pkg.sv
// amo_responder_pkg: request kinds, responder FSM states and the one-hot atomic op encoding.
package amo_responder_pkg;

    typedef enum logic [1:0] {REQ_PLAIN, REQ_LR, REQ_SC, REQ_AMO} amoReq_e;

    typedef enum logic [1:0] {AMU_IDLE, AMU_READ, AMU_WRITE, AMU_RESP} amoUnitState_e;

    typedef enum logic [9:0] {
        AMONOP    = 10'b00_0000_0001,
        AMOSWAP_W = 10'b00_0000_0010,
        AMOADD_W  = 10'b00_0000_0100,
        AMOXOR_W  = 10'b00_0000_1000,
        AMOAND_W  = 10'b00_0001_0000,
        AMOOR_W   = 10'b00_0010_0000,
        AMOMIN_W  = 10'b00_0100_0000,
        AMOMAX_W  = 10'b00_1000_0000,
        AMOMINU_W = 10'b01_0000_0000,
        AMOMAXU_W = 10'b10_0000_0000
    } iTypeAtomic_e;

endpackage

// File: rtl/amo_responder_if.sv
// amo_responder_if: core request/response, snoop and RAM signals of the atomic responder.
interface amo_responder_if;
    import amo_responder_pkg::*;
    logic         req_valid_i;
    logic         req_ready_o;
    amoReq_e      req_kind_i;
    logic [31:0]  req_addr_i;
    logic [3:0]   req_we_i;
    logic [31:0]  req_wdata_i;
    iTypeAtomic_e req_amo_op_i;
    logic         rsp_valid_o;
    logic [31:0]  rsp_rdata_o;
    logic         rsp_err_o;
    logic         snoop_valid_i;
    logic [31:0]  snoop_addr_i;
    logic         mem_en_o;
    logic [3:0]   mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [31:0]  mem_wdata_o;
    logic [31:0]  mem_rdata_i;

    modport master (
        output req_valid_i, req_kind_i, req_addr_i, req_we_i, req_wdata_i, req_amo_op_i,
        output snoop_valid_i, snoop_addr_i, mem_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport slave (
        input  req_valid_i, req_kind_i, req_addr_i, req_we_i, req_wdata_i, req_amo_op_i,
        input  snoop_valid_i, snoop_addr_i, mem_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/amo_alu.sv
// amo_alu: combinational read-modify-write result for one-hot Zaamo ops; equal operands keep old.
module amo_alu
    import amo_responder_pkg::*;
(
    input  iTypeAtomic_e op,
    input  logic [31:0]  old_val,
    input  logic [31:0]  rs2,
    output logic [31:0]  new_val
);
    logic gt_s, gt_u, lt_s, lt_u;
    always_comb begin
        gt_s = $signed(rs2) > $signed(old_val);
        lt_s = $signed(rs2) < $signed(old_val);
        gt_u = rs2 > old_val;
        lt_u = rs2 < old_val;
        new_val = op == AMOSWAP_W ? rs2 :
                  op == AMOADD_W  ? old_val + rs2 :
                  op == AMOXOR_W  ? old_val ^ rs2 :
                  op == AMOAND_W  ? old_val & rs2 :
                  op == AMOOR_W   ? old_val | rs2 :
                  op == AMOMIN_W  ? (lt_s ? rs2 : old_val) :
                  op == AMOMAX_W  ? (gt_s ? rs2 : old_val) :
                  op == AMOMINU_W ? (lt_u ? rs2 : old_val) :
                  op == AMOMAXU_W ? (gt_u ? rs2 : old_val) : old_val;
    end
endmodule

// File: rtl/amo_responder.sv
// amo_responder: memory-side target for plain, LR/SC and AMO requests in front of a single-port RAM.
module amo_responder
    import amo_responder_pkg::*;
(
    input logic            clk,
    input logic            reset,
    amo_responder_if.slave bus
);
    amoUnitState_e state;
    amoReq_e       kind_q;
    iTypeAtomic_e  op_q;
    logic [31:0]   addr_q, wdata_q, old_q, new_q, alu_out;
    logic          res_valid_q;
    logic [29:0]   res_addr_q;
    logic          idle, go, err, sc_ok, snoop_req, snoop_res, snoop_lr, wr_hit, lr_set;
    logic          unused_snoop_lsb;

    assign unused_snoop_lsb = ^bus.snoop_addr_i[1:0];

    amo_alu u_alu (.op(op_q), .old_val(bus.mem_rdata_i), .rs2(wdata_q), .new_val(alu_out));

    always_comb begin
        idle = state == AMU_IDLE;
        go = idle && bus.req_valid_i;
        err = (bus.req_kind_i != REQ_PLAIN && bus.req_addr_i[1:0] != 2'b00) ||
              (bus.req_kind_i == REQ_AMO && (bus.req_amo_op_i == AMONOP || !$onehot(bus.req_amo_op_i)));
        snoop_req = bus.snoop_valid_i && bus.snoop_addr_i[31:2] == bus.req_addr_i[31:2];
        snoop_res = bus.snoop_valid_i && bus.snoop_addr_i[31:2] == res_addr_q;
        snoop_lr = bus.snoop_valid_i && bus.snoop_addr_i[31:2] == addr_q[31:2];
        sc_ok = res_valid_q && res_addr_q == bus.req_addr_i[31:2] && !snoop_req;
        bus.req_ready_o = idle;
        bus.mem_en_o = go ? !err && (bus.req_kind_i != REQ_SC || sc_ok) : state == AMU_WRITE;
        bus.mem_we_o = go && !err ? (bus.req_kind_i == REQ_PLAIN ? bus.req_we_i :
                                     bus.req_kind_i == REQ_SC && sc_ok ? 4'hF : 4'h0) :
                       state == AMU_WRITE ? 4'hF : 4'h0;
        bus.mem_addr_o = idle ? bus.req_addr_i : addr_q;
        bus.mem_wdata_o = idle ? bus.req_wdata_i : new_q;
        wr_hit = bus.mem_en_o && |bus.mem_we_o && bus.mem_addr_o[31:2] == res_addr_q;
        lr_set = state == AMU_READ && kind_q == REQ_LR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= AMU_IDLE;
            bus.rsp_valid_o <= 1'b0;
            bus.rsp_rdata_o <= '0;
            bus.rsp_err_o <= 1'b0;
        end else begin
            bus.rsp_valid_o <= 1'b0;
            case (state)
                AMU_IDLE: if (bus.req_valid_i) begin
                    kind_q <= bus.req_kind_i;
                    addr_q <= bus.req_addr_i;
                    wdata_q <= bus.req_wdata_i;
                    op_q <= bus.req_amo_op_i;
                    if (err || bus.req_kind_i == REQ_SC || (bus.req_kind_i == REQ_PLAIN && |bus.req_we_i)) begin
                        state <= AMU_RESP;
                        bus.rsp_valid_o <= 1'b1;
                        bus.rsp_err_o <= err;
                        bus.rsp_rdata_o <= !err && bus.req_kind_i == REQ_SC ? {31'b0, !sc_ok} : 32'b0;
                    end else begin
                        state <= AMU_READ;
                    end
                end
                AMU_READ: begin
                    old_q <= bus.mem_rdata_i;
                    new_q <= alu_out;
                    if (kind_q == REQ_AMO) begin
                        state <= AMU_WRITE;
                    end else begin
                        state <= AMU_RESP;
                        bus.rsp_valid_o <= 1'b1;
                        bus.rsp_err_o <= 1'b0;
                        bus.rsp_rdata_o <= bus.mem_rdata_i;
                    end
                end
                AMU_WRITE: begin
                    state <= AMU_RESP;
                    bus.rsp_valid_o <= 1'b1;
                    bus.rsp_err_o <= 1'b0;
                    bus.rsp_rdata_o <= old_q;
                end
                default: state <= AMU_IDLE;
            endcase
        end
    end

    // A snoop to the word being reserved by an LR in the same cycle leaves it invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid_q <= 1'b0;
            res_addr_q <= '0;
        end else if (lr_set) begin
            res_valid_q <= !snoop_lr;
            res_addr_q <= addr_q[31:2];
        end else if (snoop_res || wr_hit || (go && !err && bus.req_kind_i == REQ_SC)) begin
            res_valid_q <= 1'b0;
        end
    end
endmodule

// File: doc/amo_responder.md
# amo_responder

Memory-side responder for the RS5 data bus, placed between the core's data interface and a single-port synchronous RAM. It serves plain loads and stores. It also executes Zaamo read-modify-write operations and Zalrsc LR.W/SC.W with a one-word reservation register. It is the target end of the atomic requests the core issues when built with AMO_ZALRSC, AMO_ZAAMO or AMO_A.

## Interface
- `RESET_VECTOR`, none: the block has no parameters. Memory width is fixed at 32 bits and addresses at 32 bits.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `req_valid_i`  in  1  the core presents a request.
- `req_ready_o`  out  1  the block accepts a request. High only in AMU_IDLE.
- `req_kind_i`  in  2  request kind, `amoReq_e`: REQ_PLAIN, REQ_LR, REQ_SC, REQ_AMO.
- `req_addr_i`  in  32  byte address.
- `req_we_i`  in  4  byte enables for a PLAIN request. 0 means a load. Ignored for other kinds.
- `req_wdata_i`  in  32  store data, SC data, or the AMO rs2 operand.
- `req_amo_op_i`  in  10  `iTypeAtomic_e`, one-hot. Used only when the kind is REQ_AMO.
- `rsp_valid_o`  out  1  one-cycle response pulse. Registered. There is no backpressure.
- `rsp_rdata_o`  out  32  load data, the old memory value for AMO, or the SC result (0 = success, 1 = fail).
- `rsp_err_o`  out  1  misaligned LR/SC/AMO, or an illegal AMO op.
- `snoop_valid_i`  in  1  another bus master writes memory this cycle.
- `snoop_addr_i`  in  32  address of that write.
- `mem_en_o`  out  1  RAM enable.
- `mem_we_o`  out  4  RAM byte write enables.
- `mem_addr_o`  out  32  RAM address.
- `mem_wdata_o`  out  32  RAM write data.
- `mem_rdata_i`  in  32  RAM read data. Valid exactly one cycle after a read enable.

## Operation
- FSM `amoUnitState_e` has four states: AMU_IDLE, AMU_READ, AMU_WRITE, AMU_RESP.
- Request acceptance: a request is accepted when `req_valid_i && req_ready_o`. The request fields are latched in that cycle. Memory outputs in AMU_IDLE are combinational from the request; in every other state they come from latched registers.
- PLAIN load: read in the accept cycle, then AMU_READ latches `mem_rdata_i`, then AMU_RESP.
- PLAIN store: write in the accept cycle with `mem_we_o = req_we_i`, then AMU_RESP with rdata 0.
- LR: same as a load. In AMU_READ it sets `res_valid_q = 1` and `res_addr_q = addr[31:2]`.
- SC, success case: the reservation is valid, matches `addr[31:2]`, and no matching snoop occurs in the accept cycle. The block writes 4'b1111 in the accept cycle and returns rdata 0.
- SC, fail case: no memory access, rdata 1.
- SC always clears the reservation. Next state is AMU_RESP.
- AMO: read in the accept cycle. AMU_READ latches `old_q` and computes `new_q`. AMU_WRITE writes `new_q` with 4'b1111. AMU_RESP returns `old_q`.
- AMO arithmetic on 32-bit operands `old`, `rs2`:
  - SWAP gives rs2.
  - ADD gives (old+rs2) mod 2^32, wrapping with no flag.
  - XOR, AND, OR are bitwise.
  - MIN and MAX compare signed. MINU and MAXU compare unsigned.
  - On equal operands the result is `old`.
- Error path: an LR/SC/AMO with `addr[1:0] != 0` is an error. So is an AMO whose op is AMONOP or not one-hot. The block makes no memory access, leaves the reservation untouched, goes to AMU_RESP, and returns `rsp_err_o = 1` with rdata 0. PLAIN requests are never errors.
- Reservation clear: the reservation is cleared by a PLAIN store or AMO write to the reserved word (in the cycle the write is issued), by a matching `snoop_valid_i`, or by reset. When a clear and an LR set happen in the same cycle, the clear wins.
- AMU_RESP: `rsp_valid_o = 1` for one cycle, then AMU_IDLE.

## Timing
- Reset values:
  - state AMU_IDLE.
  - `rsp_valid_o = 0`, `rsp_rdata_o = 0`, `rsp_err_o = 0`.
  - `res_valid_q = 0`.
  - `mem_en_o = 0` and `mem_we_o = 0` in the cycle after reset deasserts, unless a request is present.
- Latency from the accept cycle T:
  - Load or LR: `rsp_valid_o` at T+2.
  - Store, SC or error: T+1.
  - AMO: T+3.
- Throughput: one request per latency+1 cycles. `req_ready_o` is low in every state except AMU_IDLE.
- Reset mid-operation: the FSM returns to AMU_IDLE on the next edge and any pending write is dropped. The reset cycle itself does not block a write already issued to the RAM. No response is produced for the aborted request.
- Snoop with an AMO in flight: the snoop clears the reservation only. AMO atomicity relies on the single-port RAM.

## Structure
- Added to `RS5_pkg`:
  - `amoReq_e` (logic[1:0]).
  - `amoUnitState_e` (logic[1:0]).
  - Reuses the existing `iTypeAtomic_e`.
- Sub-module `amo_alu`: combinational. Inputs are `iTypeAtomic_e`, old and rs2. Output is new. It is verified standalone.

## Test plan
- AMO with AMOADD at 0x100:
  - Stimulus: RAM[0x100] = 0xFFFFFFFF, rs2 = 2.
  - Required response: rdata 0xFFFFFFFF at T+3, and RAM[0x100] = 0x00000001.
- Signed vs unsigned min at 0x104:
  - Stimulus: RAM[0x104] = 0x80000000. Issue AMOMIN with rs2 = 5, then reload RAM[0x104] = 0x80000000 and issue AMOMINU with rs2 = 5.
  - Required response: after AMOMIN the RAM holds 0x80000000; after AMOMINU it holds 5.
- LR/SC pair:
  - Stimulus: LR 0x200, then SC 0x200 with wdata 0xABCD.
  - Required response: SC rdata 0, RAM = 0xABCD.
  - A second SC to 0x200 then returns rdata 1 and leaves RAM unchanged.
- Snoop breaks the reservation:
  - Stimulus: LR 0x200, then snoop to 0x202, then SC 0x200.
  - Required response: SC rdata 1.
  - Also drive a snoop in the same cycle as the LR's AMU_READ; the reservation must stay invalid.
- Error path:
  - Stimulus: AMO at 0x101, then an AMO with op 0x003.
  - Required response: `rsp_err_o = 1` at T+1, no `mem_en_o` pulse, reservation unchanged.
- Reset during AMU_READ of an AMOSWAP:
  - Required response: no write, no `rsp_valid_o`, and `req_ready_o = 1` one cycle after reset deasserts.
